// File: rtl/riscv_pkg.sv
// Shared RV32I core types: register-specifier width, x0 constant, forwarding select encoding.
package riscv_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding source select for one Execute operand; Memory wins over Writeback, x0 never forwards.
module fwd_sel
    import riscv_pkg::*;
#(
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] RsE,
    input  logic [REGW-1:0] RdM,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output fwd_sel_t        Sel
);

    logic w_rs_nz;

    assign w_rs_nz = (RsE != REGW'(REG_X0));

    // Priority select: M stage result is younger, so it shadows W.
    always_comb begin
        Sel = FWD_NONE;
        if (w_rs_nz && (RsE == RdM) && RegWriteM) begin
            Sel = FWD_M;
        end else if (w_rs_nz && (RsE == RdW) && RegWriteW) begin
            Sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage RV32I hazard unit: load-use stall, branch flush and operand forwarding.
// Keeps private E/M/W copies of the register specifiers.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            PCSrcE,
    input  logic            ResultSrcEb0,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [1:0]      ForwardAE,
`ifdef HAZARD_PERF_EN
    output logic [1:0]      ForwardBE,
    output logic [CNTW-1:0] StallCnt,
    output logic [CNTW-1:0] FlushCnt
`else
    output logic [1:0]      ForwardBE
`endif
);

    logic [REGW-1:0] r_rs1_e;
    logic [REGW-1:0] r_rs2_e;
    logic [REGW-1:0] r_rd_e;
    logic [REGW-1:0] r_rd_m;
    logic [REGW-1:0] r_rd_w;

    logic            w_lw_stall;
    logic            w_flush_e;
    fwd_sel_t        w_fwd_a;
    fwd_sel_t        w_fwd_b;

    // Load in Execute whose rd is read by the instruction in Decode.
    assign w_lw_stall = ResultSrcEb0
                      && (r_rd_e != REGW'(REG_X0))
                      && ((Rs1D == r_rd_e) || (Rs2D == r_rd_e));

    assign w_flush_e = w_lw_stall || PCSrcE;

    assign StallF    = w_lw_stall;
    assign StallD    = w_lw_stall;
    assign FlushD    = PCSrcE;
    assign FlushE    = w_flush_e;
    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;

    // Specifier pipeline: E follows Decode (bubble on FlushE), M and W just shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs1_e <= '0;
            r_rs2_e <= '0;
            r_rd_e  <= '0;
            r_rd_m  <= '0;
            r_rd_w  <= '0;
        end else begin
            if (w_flush_e) begin
                r_rs1_e <= '0;
                r_rs2_e <= '0;
                r_rd_e  <= '0;
            end else begin
                r_rs1_e <= Rs1D;
                r_rs2_e <= Rs2D;
                r_rd_e  <= RdD;
            end
            r_rd_m <= r_rd_e;
            r_rd_w <= r_rd_m;
        end
    end

    fwd_sel #(
        .REGW (REGW)
    ) u_fwd_a (
        .RsE       (r_rs1_e),
        .RdM       (r_rd_m),
        .RdW       (r_rd_w),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Sel       (w_fwd_a)
    );

    fwd_sel #(
        .REGW (REGW)
    ) u_fwd_b (
        .RsE       (r_rs2_e),
        .RdM       (r_rd_m),
        .RdW       (r_rd_w),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Sel       (w_fwd_b)
    );

`ifdef HAZARD_PERF_EN
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;

    // Saturating event counters: load-use stall cycles and taken-branch cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lw_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if (PCSrcE && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end
`endif

endmodule
